tt_query_arbiter: RTL and testbench

//   Shares one TT shortest-path engine among NUM_REQ requesters. Each requester streams an

---
 rtl/tt_arb_pkg.sv | 21 ++
 rtl/tt_edge_buf.sv | 27 ++
 rtl/tt_query_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_tt_query_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_arb_pkg.sv
// tt_arb_pkg: shared types and constants for the TT query arbiter.
// Holds the FSM state enum, the edge beat struct and the error cost code.
package tt_arb_pkg;

  localparam int STN_W = 4;
  localparam logic [STN_W-1:0] COST_ERR = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [STN_W-1:0] src;
    logic [STN_W-1:0] dst;
  } edge_t;

endpackage

// File: rtl/tt_edge_buf.sv
// tt_edge_buf: burst edge storage, one write port and one async read port.
// Storage is not reset; validity is tracked by the arbiter's edge count.
module tt_edge_buf
  import tt_arb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  edge_t         wr_data,
  input  logic [IW-1:0] rd_idx,
  output edge_t         rd_data
);

  edge_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/tt_query_arbiter.sv
// tt_query_arbiter: round-robin front end sharing one TT shortest-path engine.
// Define TT_ARB_TIMEOUT_EN to give up on a silent TT after WAIT_MAX cycles.
module tt_query_arbiter
  import tt_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_EDGES = 16,
  parameter int WAIT_MAX  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_src,
  input  logic [4*NUM_REQ-1:0] req_dst,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [3:0]           rsp_cost,
  output logic                 rsp_err,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic                 tt_in_valid,
  output logic [3:0]           tt_source,
  output logic [3:0]           tt_destination,
  input  logic                 tt_out_valid,
  input  logic [3:0]           tt_cost
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_EDGES + 1);
  localparam int IW = (MAX_EDGES > 1) ? $clog2(MAX_EDGES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_EDGES);

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant;
  logic [GW-1:0] pick;
  logic [GW-1:0] next_ptr;
  logic          found;
  logic [CW-1:0] count;
  logic [CW-1:0] rd_idx;
  logic          ovf;
  logic [3:0]    cost_q;
  logic          err_q;
  logic          beat;
  logic          room;
  logic          wr_en;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] grant_oh;
  edge_t         wr_edge;
  edge_t         rd_edge;

`ifdef TT_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
  logic [7:0] wait_cnt;
`endif

  // First requesting index at or after the pointer, wrapping.
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    pick = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick = GW'(j);
      end
    end
  end

  assign next_ptr = (int'(pick) == NUM_REQ - 1) ? '0 : pick + GW'(1);
  assign pick_oh  = NUM_REQ'(1) << pick;
  assign grant_oh = NUM_REQ'(1) << grant;

  assign beat    = (state == LOAD) && req_valid[grant];
  assign room    = count < CNT_MAX;
  assign wr_en   = beat && room;
  assign wr_edge = '{
    src: req_src[grant*STN_W +: STN_W],
    dst: req_dst[grant*STN_W +: STN_W]
  };

  tt_edge_buf #(
    .DEPTH(MAX_EDGES),
    .IW   (IW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (count[IW-1:0]),
    .wr_data(wr_edge),
    .rd_idx (rd_idx[IW-1:0]),
    .rd_data(rd_edge)
  );

  assign tt_source      = tt_in_valid ? rd_edge.src : '0;
  assign tt_destination = tt_in_valid ? rd_edge.dst : '0;
  assign rsp_cost       = cost_q;
  assign rsp_err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      count       <= '0;
      rd_idx      <= '0;
      ovf         <= 1'b0;
      cost_q      <= '0;
      err_q       <= 1'b0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      tt_in_valid <= 1'b0;
`ifdef TT_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant     <= pick;
            rr_ptr    <= next_ptr;
            req_ready <= pick_oh;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (beat) begin
            if (room) count <= count + CW'(1);
            else      ovf   <= 1'b1;
            if (req_last[grant]) begin
              req_ready <= '0;
              if (ovf || !room) begin
                cost_q    <= COST_ERR;
                err_q     <= 1'b1;
                rsp_valid <= grant_oh;
                state     <= RESP;
              end else begin
                rd_idx      <= '0;
                tt_in_valid <= 1'b1;
                state       <= SEND;
              end
            end
          end
        end
        SEND: begin
          if (rd_idx == count - CW'(1)) begin
            tt_in_valid <= 1'b0;
            state       <= WAIT;
`ifdef TT_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end else begin
            rd_idx <= rd_idx + CW'(1);
          end
        end
        WAIT: begin
          // A response in the expiry cycle still wins over the timeout.
          if (tt_out_valid) begin
            cost_q    <= tt_cost;
            err_q     <= 1'b0;
            rsp_valid <= grant_oh;
            state     <= RESP;
          end
`ifdef TT_ARB_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            cost_q    <= COST_ERR;
            err_q     <= 1'b1;
            rsp_valid <= grant_oh;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            rsp_valid <= '0;
            cost_q    <= '0;
            err_q     <= 1'b0;
            count     <= '0;
            rd_idx    <= '0;
            ovf       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_query_arbiter.sv
// tb_tt_query_arbiter: directed plus random queries against a queue-based model.
// Set TT_ARB_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_tt_query_arbiter;

  localparam int N  = 4;
  localparam int ME = 16;
  localparam int WM = 255;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_src;
  logic [4*N-1:0] req_dst;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [3:0]     rsp_cost;
  logic           rsp_err;
  logic [N-1:0]   rsp_ready;
  logic           tt_in_valid;
  logic [3:0]     tt_source;
  logic [3:0]     tt_destination;
  logic           tt_out_valid;
  logic [3:0]     tt_cost;

  tt_query_arbiter #(
    .NUM_REQ  (N),
    .MAX_EDGES(ME),
    .WAIT_MAX (WM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_src       (req_src),
    .req_dst       (req_dst),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_cost      (rsp_cost),
    .rsp_err       (rsp_err),
    .rsp_ready     (rsp_ready),
    .tt_in_valid   (tt_in_valid),
    .tt_source     (tt_source),
    .tt_destination(tt_destination),
    .tt_out_valid  (tt_out_valid),
    .tt_cost       (tt_cost)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  int runs  = 0;
  logic prev_v = 1'b0;
  logic [7:0] tt_q[$];
  logic [7:0] exp_edges[$];
  int base_runs;

  // TT-side observer: every in_valid beat and every rising edge of in_valid.
  always @(negedge clk) begin
    if (tt_in_valid) tt_q.push_back({tt_source, tt_destination});
    if (tt_in_valid && !prev_v) runs++;
    prev_v = tt_in_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_src = '0; req_dst = '0; req_last = '0;
    rsp_ready = '0; tt_out_valid = 1'b0; tt_cost = '0;
    tick();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, 32'(req_ready), 0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 0);
    chk({tag, "_cost"}, 32'(rsp_cost), 0);
    chk({tag, "_err"}, 32'(rsp_err), 0);
    chk({tag, "_ttv"}, 32'(tt_in_valid), 0);
    chk({tag, "_tts"}, 32'({tt_source, tt_destination}), 0);
  endtask

  // Streams n random edges from requester r, optionally pausing mid-burst.
  task automatic drive_burst(input int r, input int n, input int gap_at,
                             input int gap_len);
    int k, gap, bud;
    logic acc;
    logic [N-1:0] mine;
    logic [7:0] e;
    mine = N'(1) << r;
    exp_edges.delete();
    for (int i = 0; i < n; i++) begin
      e = 8'($urandom);
      exp_edges.push_back(e);
    end
    tt_q.delete();
    base_runs = runs;
    k = 0; gap = 0; bud = 0;
    while (k < n && bud < 200) begin
      if (k == gap_at && gap < gap_len) begin
        req_valid[r] = 1'b0;
        gap++;
      end else begin
        req_valid[r] = 1'b1;
        req_src[r*4 +: 4] = exp_edges[k][7:4];
        req_dst[r*4 +: 4] = exp_edges[k][3:0];
        req_last[r] = (k == n - 1);
      end
      acc = req_ready[r] && req_valid[r];
      chk("other_ready", 32'(req_ready & ~mine), 0);
      chk("other_rspv", 32'(rsp_valid), 0);
      tick();
      if (bud == 0) begin
        chk("grant_latency", 32'(req_ready), 32'(mine));
        ptr_m = (r + 1) % N;
      end
      bud++;
      if (acc) k++;
    end
    chk("burst_accepted", 32'(k), 32'(n));
    req_valid[r] = 1'b0;
    req_last[r] = 1'b0;
  endtask

  task automatic check_send(input int n);
    int c;
    c = 0;
    chk("send_start", 32'(tt_in_valid), 1);
    chk("send_noready", 32'(req_ready), 0);
    while (tt_in_valid && c < ME + 4) begin
      c++;
      tick();
    end
    chk("send_len", 32'(c), 32'(n));
    chk("send_runs", 32'(runs - base_runs), 1);
    chk("send_beats", 32'(tt_q.size()), 32'(n));
    for (int i = 0; i < n && i < tt_q.size(); i++) begin
      chk("edge_order", 32'(tt_q[i]), 32'(exp_edges[i]));
    end
  endtask

  task automatic tt_reply(input logic [3:0] cost, input int delay);
    repeat (delay) tick();
    chk("wait_no_rsp", 32'(rsp_valid), 0);
    tt_out_valid = 1'b1;
    tt_cost = cost;
    tick();
    tt_out_valid = 1'b0;
  endtask

  // Response must hold while rsp_ready is low, even with stray TT pulses.
  task automatic check_rsp(input int r, input logic [3:0] cost,
                           input logic err, input int hold);
    logic [N-1:0] mine;
    mine = N'(1) << r;
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(mine));
      chk("rsp_cost", 32'(rsp_cost), 32'(cost));
      chk("rsp_err", 32'(rsp_err), 32'(err));
      tt_out_valid = (h == 0);
      tt_cost = ~cost;
      tick();
      tt_out_valid = 1'b0;
    end
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready[r] = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 0);
    chk("rsp_no_ttv", 32'(tt_in_valid), 0);
  endtask

  task automatic query(input int r, input int n, input int gap_at,
                       input int gap_len, input logic [3:0] cost,
                       input int delay, input int hold);
    drive_burst(r, n, gap_at, gap_len);
    if (n > ME) begin
      chk("ovf_no_send", 32'(tt_in_valid), 0);
      check_rsp(r, 4'hF, 1'b1, hold);
      chk("ovf_no_runs", 32'(runs - base_runs), 0);
    end else begin
      check_send(n);
      tt_reply(cost, delay);
      check_rsp(r, cost, 1'b0, hold);
    end
  endtask

  initial begin
    int g, c, r, n;
    do_reset();
    rst = 1'b1;
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Simultaneous requests: four rounds plus a wrap.
    for (int i = 0; i < N; i++) begin
      req_src[i*4 +: 4] = 4'(i);
      req_dst[i*4 +: 4] = 4'(i + 8);
    end
    req_valid = '1; req_last = '1; rsp_ready = '1;
    for (int rd = 0; rd < 5; rd++) begin
      c = 0;
      while (req_ready == '0 && c < 10) begin
        tick();
        c++;
      end
      g = rr_pick('1, ptr_m);
      ptr_m = (g + 1) % N;
      chk("rr_grant", 32'(req_ready), 32'(N'(1) << g));
      tick();
      chk("rr_send", 32'(tt_in_valid), 1);
      chk("rr_src", 32'(tt_source), 32'(g));
      tick();
      tt_out_valid = 1'b1;
      tt_cost = 4'(g + 3);
      tick();
      tt_out_valid = 1'b0;
      chk("rr_rspv", 32'(rsp_valid), 32'(N'(1) << g));
      chk("rr_cost", 32'(rsp_cost), 32'(g + 3));
      if (rd == 4) req_valid = '0;
      tick();
    end
    req_last = '0; rsp_ready = '0;
    tick();

    // Three-edge burst from req0 with fixed edges.
    exp_edges.delete();
    tt_q.delete();
    base_runs = runs;
    req_valid[0] = 1'b1;
    req_src[3:0] = 4'd0;
    req_dst[3:0] = 4'd1;
    tick();
    chk("t1_grant", 32'(req_ready), 1);
    ptr_m = 1;
    for (int k = 0; k < 3; k++) begin
      req_src[3:0] = 4'(k == 0 ? 0 : (k == 1 ? 1 : 2));
      req_dst[3:0] = 4'(k == 0 ? 1 : (k == 1 ? 2 : 5));
      req_last[0] = (k == 2);
      exp_edges.push_back({req_src[3:0], req_dst[3:0]});
      tick();
    end
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    check_send(3);
    tt_reply(4'd2, 2);
    check_rsp(0, 4'd2, 1'b0, 1);

    // Overflow by one, then exactly full.
    query(2, ME + 1, 0, 0, 4'd7, 1, 1);
    query(2, ME, 0, 0, 4'd9, 0, 0);

    // Mid-burst stall and slow response accept.
    query(1, 6, 3, 5, 4'd4, 3, 4);

    // Silent TT.
    drive_burst(3, 2, 0, 0);
    check_send(2);
`ifdef TT_ARB_TIMEOUT_EN
    c = 0;
    while (!rsp_valid[3] && c < 2 * WM) begin
      tick();
      c++;
    end
    chk("timeout_cycles", 32'(c), 32'(WM));
    check_rsp(3, 4'hF, 1'b1, 0);
`else
    repeat (300) tick();
    chk("no_timeout", 32'(rsp_valid), 0);
    tt_reply(4'd6, 0);
    check_rsp(3, 4'd6, 1'b0, 0);
`endif

    // Random queries.
    for (int t = 0; t < 16; t++) begin
      r = $urandom_range(0, N - 1);
      n = (t % 5 == 4) ? $urandom_range(ME + 1, ME + 3) : $urandom_range(1, ME);
      query(r, n, (n > 1) ? $urandom_range(1, n - 1) : 0,
            $urandom_range(0, 3), 4'($urandom), $urandom_range(0, 6),
            $urandom_range(0, 3));
    end

    // Reset during SEND, then grant from pointer 0.
    drive_burst(2, 8, 0, 0);
    tick();
    tick();
    chk("pre_rst_send", 32'(tt_in_valid), 1);
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    ptr_m = 0;
    tick();
    chk_zero("postrst");
    req_valid = 4'b1010;
    tick();
    chk("rst_ptr_grant", 32'(req_ready), 32'(N'(1) << rr_pick(4'b1010, ptr_m)));
    do_reset();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
